// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling FSM, and a
// one-entry output register with valid/ready handshake plus error pulses.
`timescale 1ns/1ps
module uart_rx #(
   parameter int CLKS_PER_BIT = 435,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2,
   parameter int CNT_W        = 16
) (
   input  logic       rx_clk,
   input  logic       rx_rst,
   input  logic       rx_serial_in,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_q, sync2_q, prev_q;
   logic             init_q, armed_q, armed_d;
   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             done_q, done_d;
   logic             ferr_q, ferr_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             s;

   assign s = sync2_q;

   // Start edges only count once the line has been seen high after reset,
   // so releasing reset while the line is low mid-frame cannot fake a start.
   assign armed_d = armed_q | (init_q & sync1_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (armed_q && prev_q && !s) state_d = S_START;
         end
         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d   = '0;
               shift_d = {s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_STOP: begin
            if (cnt_q == CNT_FULL) begin
               cnt_d = '0;
               if (s) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (s) state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Output buffer: a completed byte loads if the slot is empty or draining.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (done_q) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge rx_clk or posedge rx_rst) begin
      if (rx_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         init_q  <= 1'b0;
         armed_q <= 1'b0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         sync1_q <= rx_serial_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         init_q  <= 1'b1;
         armed_q <= armed_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;
   assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected bytes are queued as frames are sent
// and popped on every rx_valid && rx_ready beat.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int CPB = 435;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid, ferr, ovr, busy;

   int vectors = 0;
   int miscompares = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int beats = 0;
   logic [7:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(CPB / 2), .CNT_W(16)) dut (
      .rx_clk(clk),
      .rx_rst(rst),
      .rx_serial_in(line),
      .rx_data(data),
      .rx_valid(valid),
      .rx_ready(ready),
      .rx_frame_err(ferr),
      .rx_overrun(ovr),
      .rx_busy(busy)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: score handshake beats and count error pulses.
   always @(negedge clk) begin
      if (!rst) begin
         if (ferr) ferr_cnt++;
         if (ovr) ovr_cnt++;
         if (valid && ready) begin
            beats++;
            if (exp_q.size() == 0) check_eq("unexpected_beat", {24'd0, data}, 32'hFFFF_FFFF);
            else check_eq("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      line = 1'b0;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         wait_clks(CPB);
      end
      line = stop;
      wait_clks(CPB);
   endtask

   task automatic set_ready(input logic r);
      @(posedge clk);
      #1 ready = r;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      wait_clks(5);
      check_eq("rst_data", {24'd0, data}, 32'h0);
      check_eq("rst_valid", {31'd0, valid}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_ferr", {31'd0, ferr}, 32'd0);
      check_eq("rst_ovr", {31'd0, ovr}, 32'd0);
      rst = 1'b0;
      wait_clks(50);

      // Single byte
      b0 = beats;
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      wait_clks(20);
      check_eq("single_beats", beats - b0, 1);
      check_eq("single_qempty", exp_q.size(), 0);
      check_eq("single_valid_low", {31'd0, valid}, 32'd0);
      check_eq("single_ferr", ferr_cnt, 0);

      // Back-to-back frames, no idle gap
      b0 = beats;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(8'h41 + 8'(i));
         send_frame(8'h41 + 8'(i), 1'b1);
      end
      wait_clks(20);
      check_eq("b2b_beats", beats - b0, 4);
      check_eq("b2b_qempty", exp_q.size(), 0);
      check_eq("b2b_ovr", ovr_cnt, 0);

      // Glitch on the line
      b0 = beats;
      line = 1'b0;
      wait_clks(50);
      check_eq("glitch_busy_hi", {31'd0, busy}, 32'd1);
      wait_clks(50);
      line = 1'b1;
      wait_clks(500);
      check_eq("glitch_busy_lo", {31'd0, busy}, 32'd0);
      check_eq("glitch_beats", beats - b0, 0);
      check_eq("glitch_ferr", ferr_cnt, 0);

      // Framing error followed by a long break
      b0 = beats;
      send_frame(8'h55, 1'b0);
      wait_clks(5000);
      check_eq("break_busy", {31'd0, busy}, 32'd1);
      line = 1'b1;
      wait_clks(1000);
      check_eq("break_ferr", ferr_cnt, 1);
      check_eq("break_beats", beats - b0, 0);
      check_eq("break_idle", {31'd0, busy}, 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_clks(20);
      check_eq("after_break_qempty", exp_q.size(), 0);
      check_eq("after_break_ferr", ferr_cnt, 1);

      // Overrun: consumer stalled
      set_ready(1'b0);
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      wait_clks(20);
      check_eq("ovr_valid", {31'd0, valid}, 32'd1);
      check_eq("ovr_data", {24'd0, data}, 32'h11);
      check_eq("ovr_cnt", ovr_cnt, 1);
      set_ready(1'b1);
      wait_clks(3);
      check_eq("ovr_drain_qempty", exp_q.size(), 0);
      check_eq("ovr_drain_valid", {31'd0, valid}, 32'd0);

      // Reset during bit 3 of 0xA5
      line = 1'b0;
      wait_clks(CPB);
      line = 1'b1; wait_clks(CPB);
      line = 1'b0; wait_clks(CPB);
      line = 1'b1; wait_clks(CPB);
      line = 1'b0; wait_clks(200);
      check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      wait_clks(3);
      check_eq("mid_rst_data", {24'd0, data}, 32'h0);
      check_eq("mid_rst_valid", {31'd0, valid}, 32'd0);
      check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      b0 = beats;
      wait_clks(1000);
      check_eq("low_after_rst_busy", {31'd0, busy}, 32'd0);
      line = 1'b1;
      wait_clks(1000);
      check_eq("low_after_rst_beats", beats - b0, 0);
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      wait_clks(20);
      check_eq("post_rst_qempty", exp_q.size(), 0);
      check_eq("post_rst_data", {24'd0, data}, 32'h3C);
      check_eq("final_ferr", ferr_cnt, 1);
      check_eq("final_ovr", ovr_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
